// File: rtl/sonar_ping_sequencer_if.sv
// Signal bundle between the sonar ping sequencer and the beamformer / time-of-flight / display side.
// master: the sequencer; slave: the surrounding datapath.
interface sonar_ping_sequencer_if #(
    parameter int ANGLE_WIDTH = 8,
    parameter int RANGE_WIDTH = 16
);
    logic                          enable_in;
    logic                          echo_valid_in;
    logic [RANGE_WIDTH-1:0]        range_in;
    logic                          ping_start_out;
    logic                          burst_active_out;
    logic                          listen_active_out;
    logic signed [ANGLE_WIDTH-1:0] beam_angle_out;
    logic                          result_valid_out;
    logic signed [ANGLE_WIDTH-1:0] result_angle_out;
    logic [RANGE_WIDTH-1:0]        result_range_out;
    logic                          result_hit_out;
    logic                          sweep_done_out;

    modport master (
        input  enable_in, echo_valid_in, range_in,
        output ping_start_out, burst_active_out, listen_active_out, beam_angle_out,
               result_valid_out, result_angle_out, result_range_out, result_hit_out,
               sweep_done_out
    );

    modport slave (
        output enable_in, echo_valid_in, range_in,
        input  ping_start_out, burst_active_out, listen_active_out, beam_angle_out,
               result_valid_out, result_angle_out, result_range_out, result_hit_out,
               sweep_done_out
    );
endinterface

// File: rtl/sonar_ping_sequencer.sv
// Sonar ping cycle sequencer: settle, burst, listen, report, with first-echo capture per ping.
// Define SONAR_SCAN_SWEEP_EN to step the beam across ANGLE_MIN..ANGLE_MAX; otherwise boresight.
module sonar_ping_sequencer #(
    parameter int BURST_CYCLES  = 524288,
    parameter int LISTEN_CYCLES = 16252928,
    parameter int SETTLE_CYCLES = 1024,
    parameter int ANGLE_WIDTH   = 8,
    parameter int ANGLE_MIN     = -30,
    parameter int ANGLE_MAX     = 30,
    parameter int ANGLE_STEP    = 10,
    parameter int RANGE_WIDTH   = 16
) (
    input logic                  clk_in,
    input logic                  rst_in,
    sonar_ping_sequencer_if.master bus
);
    localparam int MaxBl  = (BURST_CYCLES > LISTEN_CYCLES) ? BURST_CYCLES : LISTEN_CYCLES;
    localparam int MaxDur = (MaxBl > SETTLE_CYCLES) ? MaxBl : SETTLE_CYCLES;
    localparam int CntW   = (MaxDur > 1) ? $clog2(MaxDur) : 1;

`ifdef SONAR_SCAN_SWEEP_EN
    localparam bit SweepEn = 1'b1;
`else
    localparam bit SweepEn = 1'b0;
`endif

    localparam logic signed [ANGLE_WIDTH:0]   AngleMaxW = (ANGLE_WIDTH+1)'(ANGLE_MAX);
    localparam logic signed [ANGLE_WIDTH:0]   AngleStepW = (ANGLE_WIDTH+1)'(ANGLE_STEP);
    localparam logic signed [ANGLE_WIDTH-1:0] AngleMinN = ANGLE_WIDTH'(ANGLE_MIN);
    localparam logic signed [ANGLE_WIDTH-1:0] AngleMaxN = ANGLE_WIDTH'(ANGLE_MAX);
    localparam logic signed [ANGLE_WIDTH-1:0] AngleRst = SweepEn ? AngleMinN : '0;

    typedef enum logic [2:0] {StIdle, StSettle, StBurst, StListen, StReport} state_e;

    state_e                        state_q, state_d;
    logic [CntW-1:0]               cnt_q, cnt_d;
    logic                          hit_q, hit_d;
    logic [RANGE_WIDTH-1:0]        range_q, range_d;
    logic signed [ANGLE_WIDTH-1:0] angle_q, angle_next;
    logic signed [ANGLE_WIDTH:0]   angle_sum;
    logic                          burst_entry;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (bus.enable_in) state_d = StSettle;
            StSettle: if (cnt_q == '0) state_d = StBurst;
            StBurst:  if (cnt_q == '0) state_d = StListen;
            StListen: if (cnt_q == '0) state_d = StReport;
            StReport: state_d = bus.enable_in ? StSettle : StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign burst_entry = (state_d == StBurst) && (state_q != StBurst);

    // Single down-counter reloaded on every state change; a state ends when it reaches zero.
    always_comb begin
        cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        if (state_d != state_q) begin
            case (state_d)
                StSettle: cnt_d = CntW'(SETTLE_CYCLES - 1);
                StBurst:  cnt_d = CntW'(BURST_CYCLES - 1);
                StListen: cnt_d = CntW'(LISTEN_CYCLES - 1);
                default:  cnt_d = '0;
            endcase
        end
    end

    // First strobe of the listen window wins, including one on its final cycle.
    always_comb begin
        hit_d   = hit_q;
        range_d = range_q;
        if (burst_entry) begin
            hit_d   = 1'b0;
            range_d = '0;
        end else if (state_q == StListen && bus.echo_valid_in && !hit_q) begin
            hit_d   = 1'b1;
            range_d = bus.range_in;
        end
    end

    always_comb begin
        angle_sum  = (ANGLE_WIDTH+1)'(angle_q) + AngleStepW;
        angle_next = (angle_sum > AngleMaxW) ? AngleMinN : angle_sum[ANGLE_WIDTH-1:0];
        if (!SweepEn) angle_next = '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q               <= StIdle;
            cnt_q                 <= '0;
            hit_q                 <= 1'b0;
            range_q               <= '0;
            angle_q               <= AngleRst;
            bus.ping_start_out    <= 1'b0;
            bus.burst_active_out  <= 1'b0;
            bus.listen_active_out <= 1'b0;
            bus.result_valid_out  <= 1'b0;
            bus.result_angle_out  <= '0;
            bus.result_range_out  <= '0;
            bus.result_hit_out    <= 1'b0;
            bus.sweep_done_out    <= 1'b0;
        end else begin
            state_q               <= state_d;
            cnt_q                 <= cnt_d;
            hit_q                 <= hit_d;
            range_q               <= range_d;
            if (state_q == StReport) angle_q <= angle_next;
            bus.ping_start_out    <= burst_entry;
            bus.burst_active_out  <= (state_d == StBurst);
            bus.listen_active_out <= (state_d == StListen);
            bus.result_valid_out  <= (state_d == StReport);
            bus.sweep_done_out    <= (state_d == StReport) && SweepEn && (angle_q == AngleMaxN);
            if (state_d == StReport) begin
                bus.result_angle_out <= angle_q;
                bus.result_range_out <= hit_d ? range_d : '1;
                bus.result_hit_out   <= hit_d;
            end
        end
    end

    assign bus.beam_angle_out = angle_q;
endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// Self-checking bench for sonar_ping_sequencer: ping-level timeline reference model, vector table,
// hand-written corner sequences and randomized enable/echo/reset traffic.
module tb_sonar_ping_sequencer;
    localparam int S = 2;
    localparam int B = 4;
    localparam int L = 10;
    localparam int T = S + B + L;  // ping offset of the report cycle
    localparam int AMIN = -30;
    localparam int AMAX = 30;
    localparam int ASTEP = 10;
`ifdef SONAR_SCAN_SWEEP_EN
    localparam bit SWEEP = 1'b1;
`else
    localparam bit SWEEP = 1'b0;
`endif

    typedef struct {
        int k1; int r1; int k2; int r2; bit bstrobe; bit exp_hit; int exp_range;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // Reference model: offset within the current ping (-1 when idle) plus captured results.
    int m_phase = -1;
    int m_angle = 0;
    bit m_hit = 0;
    int m_rng = 0;
    bit r_valid = 0, r_hit = 0, r_done = 0;
    int r_angle = 0, r_range = 0;

    vec_t vecs[5];
    bit   got_hit, seen;
    int   got_range;
    int   starts[$];
    int   angs[8];
    bit   dones[8];
    int   exp_ang[8];
    int   n, guard, nstart, nres;

    sonar_ping_sequencer_if #(.ANGLE_WIDTH(8), .RANGE_WIDTH(16)) bus ();

    sonar_ping_sequencer #(
        .BURST_CYCLES(B), .LISTEN_CYCLES(L), .SETTLE_CYCLES(S), .ANGLE_WIDTH(8),
        .ANGLE_MIN(AMIN), .ANGLE_MAX(AMAX), .ANGLE_STEP(ASTEP), .RANGE_WIDTH(16)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic model_update();
        int np;
        if (rst) begin
            m_phase = -1; m_angle = SWEEP ? AMIN : 0; m_hit = 0; m_rng = 0;
            r_valid = 0; r_hit = 0; r_done = 0; r_angle = 0; r_range = 0;
            return;
        end
        if (m_phase >= S + B && m_phase < T && bus.echo_valid_in && !m_hit) begin
            m_hit = 1;
            m_rng = int'(bus.range_in);
        end
        if (m_phase < 0) begin
            np = bus.enable_in ? 0 : -1;
        end else if (m_phase == T) begin
            np = bus.enable_in ? 0 : -1;
            if (SWEEP) m_angle = (m_angle + ASTEP > AMAX) ? AMIN : m_angle + ASTEP;
        end else begin
            np = m_phase + 1;
        end
        if (np == S) begin
            m_hit = 0;
            m_rng = 0;
        end
        r_valid = (np == T);
        r_done  = 0;
        if (np == T) begin
            r_angle = m_angle;
            r_hit   = m_hit;
            r_range = m_hit ? m_rng : 32'hFFFF;
            r_done  = SWEEP && (m_angle == AMAX);
        end
        m_phase = np;
    endtask

    task automatic check_all();
        chk("ping_start", bus.ping_start_out, longint'(m_phase == S));
        chk("burst_active", bus.burst_active_out, longint'(m_phase >= S && m_phase < S + B));
        chk("listen_active", bus.listen_active_out, longint'(m_phase >= S + B && m_phase < T));
        chk("beam_angle", bus.beam_angle_out, m_angle);
        chk("result_valid", bus.result_valid_out, r_valid);
        chk("result_angle", bus.result_angle_out, r_angle);
        chk("result_range", bus.result_range_out, r_range);
        chk("result_hit", bus.result_hit_out, r_hit);
        chk("sweep_done", bus.sweep_done_out, r_done);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
        cyc++;
    endtask

    // One ping from idle; echoes placed by listen-window index, optional strobe during burst.
    task automatic run_ping(input vec_t v, output bit hit, output int rng, output bit found);
        int g;
        hit = 0; rng = 0; found = 0; g = 0;
        bus.enable_in = 1'b1;
        while (!found && g < 40) begin
            bus.echo_valid_in = 1'b0;
            if (v.bstrobe && m_phase == S + 1) begin
                bus.echo_valid_in = 1'b1; bus.range_in = 16'h0BAD;
            end
            if (v.k1 >= 0 && m_phase == S + B + v.k1) begin
                bus.echo_valid_in = 1'b1; bus.range_in = 16'(v.r1);
            end
            if (v.k2 >= 0 && m_phase == S + B + v.k2) begin
                bus.echo_valid_in = 1'b1; bus.range_in = 16'(v.r2);
            end
            step();
            g++;
            bus.enable_in = 1'b0;
            if (bus.result_valid_out) begin
                found = 1; hit = bus.result_hit_out; rng = int'(bus.result_range_out);
            end
        end
        bus.echo_valid_in = 1'b0;
        step();
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_ping_start"}, bus.ping_start_out, 0);
        chk({tag, "_burst"}, bus.burst_active_out, 0);
        chk({tag, "_listen"}, bus.listen_active_out, 0);
        chk({tag, "_beam"}, bus.beam_angle_out, SWEEP ? -30 : 0);
        chk({tag, "_valid"}, bus.result_valid_out, 0);
        chk({tag, "_range"}, bus.result_range_out, 0);
        chk({tag, "_angle"}, bus.result_angle_out, 0);
        chk({tag, "_sweep_done"}, bus.sweep_done_out, 0);
    endtask

    initial begin
        vecs[0] = '{k1: 3, r1: 'h0123, k2: -1, r2: 0, bstrobe: 0, exp_hit: 1, exp_range: 'h0123};
        vecs[1] = '{k1: 2, r1: 'h0010, k2: 6, r2: 'h0020, bstrobe: 1, exp_hit: 1,
                    exp_range: 'h0010};
        vecs[2] = '{k1: -1, r1: 0, k2: -1, r2: 0, bstrobe: 1, exp_hit: 0, exp_range: 'hFFFF};
        vecs[3] = '{k1: 9, r1: 'h0777, k2: -1, r2: 0, bstrobe: 0, exp_hit: 1, exp_range: 'h0777};
        vecs[4] = '{k1: 0, r1: 'h4321, k2: 8, r2: 'h1111, bstrobe: 0, exp_hit: 1,
                    exp_range: 'h4321};
        exp_ang = '{-30, -20, -10, 0, 10, 20, 30, -30};

        bus.enable_in = 1'b0; bus.echo_valid_in = 1'b0; bus.range_in = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_reset_values("reset");
        step();

        // Vector table: one ping per row; first row carries the sweep start angle.
        for (int i = 0; i < 5; i++) begin
            if (i == 0) chk("first_ping_angle_pre", m_angle, SWEEP ? -30 : 0);
            run_ping(vecs[i], got_hit, got_range, seen);
            chk($sformatf("vec%0d_seen", i), seen, 1);
            chk($sformatf("vec%0d_hit", i), got_hit, vecs[i].exp_hit);
            chk($sformatf("vec%0d_range", i), got_range, vecs[i].exp_range);
        end

        // Continuous run of eight pings from a fresh sweep start.
        rst = 1'b1; step(); rst = 1'b0;
        n = 0; guard = 0; starts.delete();
        bus.enable_in = 1'b1;
        while (n < 8 && guard < 200) begin
            step();
            guard++;
            if (bus.ping_start_out) starts.push_back(cyc);
            if (bus.result_valid_out) begin
                angs[n] = int'(bus.result_angle_out);
                dones[n] = bus.sweep_done_out;
                n++;
                if (n == 8) bus.enable_in = 1'b0;
            end
        end
        chk("cont_results", n, 8);
        chk("cont_starts", starts.size(), 8);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("cont_angle%0d", i), angs[i], SWEEP ? exp_ang[i] : 0);
            chk($sformatf("cont_done%0d", i), dones[i], longint'(SWEEP && i == 6));
        end
        for (int i = 1; i < starts.size(); i++)
            chk($sformatf("cont_period%0d", i), starts[i] - starts[i-1], 17);
        for (int i = 0; i < 4; i++) step();

        // Enable dropped during burst: ping completes, then stays idle.
        bus.enable_in = 1'b1; guard = 0;
        while (!bus.burst_active_out && guard < 20) begin step(); guard++; end
        bus.enable_in = 1'b0;
        nres = 0; nstart = 0;
        for (int i = 0; i < T + 20; i++) begin
            step();
            if (bus.result_valid_out) nres++;
            if (bus.ping_start_out) nstart++;
        end
        chk("drop_reports", nres, 1);
        chk("drop_new_starts", nstart, 0);

        // Reset during listen aborts with no report; a later last-cycle echo is still captured.
        bus.enable_in = 1'b1; guard = 0;
        while (m_phase != S + B + 2 && guard < 40) begin step(); guard++; end
        bus.enable_in = 1'b0;
        bus.echo_valid_in = 1'b1; bus.range_in = 16'h5555;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.echo_valid_in = 1'b0;
        check_reset_values("midreset");
        nres = 0;
        for (int i = 0; i < T + 4; i++) begin
            step();
            if (bus.result_valid_out) nres++;
        end
        chk("midreset_no_report", nres, 0);
        run_ping(vecs[3], got_hit, got_range, seen);
        chk("late_echo_seen", seen, 1);
        chk("late_echo_hit", got_hit, 1);
        chk("late_echo_range", got_range, 'h0777);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus.enable_in = ($urandom_range(0, 3) != 0);
            bus.echo_valid_in = ($urandom_range(0, 2) == 0);
            bus.range_in = 16'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
